// File: rtl/sb_pkg.sv
// Shared sizes and types for the GPR hazard scoreboard.
package sb_pkg;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int CNT_W     = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_W) - 1);
endpackage

// File: rtl/rf_hazard_scoreboard_if.sv
// ID/WB-facing signal bundle of the hazard scoreboard.
// stall_cycles exists only when SB_PERF_EN is defined.
interface rf_hazard_scoreboard_if;
    import sb_pkg::*;

    logic                 id_issue_valid;
    logic                 id_issue_we;
    logic [REG_IDX_W-1:0] id_issue_waddr;
    logic                 id_rs1_valid;
    logic [REG_IDX_W-1:0] id_rs1;
    logic                 id_rs2_valid;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 wb_retire_valid;
    logic                 wb_retire_we;
    logic [REG_IDX_W-1:0] wb_retire_waddr;
    logic                 id_stall;
    logic [NUM_REGS-1:0]  busy_vec;
    logic                 sb_err;
`ifdef SB_PERF_EN
    logic [31:0]          stall_cycles;

    modport master (
        output id_issue_valid, id_issue_we, id_issue_waddr,
        output id_rs1_valid, id_rs1, id_rs2_valid, id_rs2,
        output wb_retire_valid, wb_retire_we, wb_retire_waddr,
        input  id_stall, busy_vec, sb_err, stall_cycles
    );
    modport slave (
        input  id_issue_valid, id_issue_we, id_issue_waddr,
        input  id_rs1_valid, id_rs1, id_rs2_valid, id_rs2,
        input  wb_retire_valid, wb_retire_we, wb_retire_waddr,
        output id_stall, busy_vec, sb_err, stall_cycles
    );
`else
    modport master (
        output id_issue_valid, id_issue_we, id_issue_waddr,
        output id_rs1_valid, id_rs1, id_rs2_valid, id_rs2,
        output wb_retire_valid, wb_retire_we, wb_retire_waddr,
        input  id_stall, busy_vec, sb_err
    );
    modport slave (
        input  id_issue_valid, id_issue_we, id_issue_waddr,
        input  id_rs1_valid, id_rs1, id_rs2_valid, id_rs2,
        input  wb_retire_valid, wb_retire_we, wb_retire_waddr,
        output id_stall, busy_vec, sb_err
    );
`endif
endinterface

// File: rtl/sb_reg_counter.sv
// Saturating up/down count of in-flight writes to one GPR.
// err_o pulses when an increment hits the ceiling or a decrement hits zero.
module sb_reg_counter
    import sb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic busy_o,
    output logic err_o
);
    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        // Simultaneous issue and retire of the same register cancel out.
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) err_o = 1'b1;
            else                  cnt_d = cnt_q + cnt_t'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_o = 1'b1;
            else             cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/rf_hazard_scoreboard.sv
// Tracks un-retired GPR writes between ID issue and WB and stalls ID on RAW hazards.
// Optional stall-cycle performance counter enabled by SB_PERF_EN.
module rf_hazard_scoreboard
    import sb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    rf_hazard_scoreboard_if.slave   sb
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] cnt_err;
    logic                id_stall;
    logic                sb_err_q, sb_err_d;

    // r0 is hardwired zero and never has a pending producer.
    assign busy[0]    = 1'b0;
    assign cnt_err[0] = 1'b0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        logic inc, dec;
        assign inc = sb.id_issue_valid & sb.id_issue_we &
                     (sb.id_issue_waddr == REG_IDX_W'(gi));
        assign dec = sb.wb_retire_valid & sb.wb_retire_we &
                     (sb.wb_retire_waddr == REG_IDX_W'(gi));

        sb_reg_counter u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_i  (inc),
            .dec_i  (dec),
            .busy_o (busy[gi]),
            .err_o  (cnt_err[gi])
        );
    end

    // Registered busy only: a retire this cycle releases the stall next cycle.
    assign id_stall = (sb.id_rs1_valid & busy[sb.id_rs1]) |
                      (sb.id_rs2_valid & busy[sb.id_rs2]);

    assign sb_err_d = sb_err_q | (|cnt_err) | (sb.id_issue_valid & id_stall);

    always_ff @(posedge clk) begin
        if (rst) sb_err_q <= 1'b0;
        else     sb_err_q <= sb_err_d;
    end

    assign sb.id_stall = id_stall;
    assign sb.busy_vec = busy;
    assign sb.sb_err   = sb_err_q;

`ifdef SB_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    assign stall_cycles_d = stall_cycles_q + {31'd0, id_stall};

    always_ff @(posedge clk) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign sb.stall_cycles = stall_cycles_q;
`endif
endmodule
